vga_fb_reader: RTL
==================

// Module: vga_fb_reader
// PURPOSE
//  Parametrised framebuffer pixel fetcher sitting between the VGA timing generator and the pixel output.
//  - Maps the (pix_x, pix_y) scan position to a framebuffer address.
//  - Supports image offset, integer pixel replication (2^SCALE_SHIFT) and a background colour outside the image.
//  - Provides frame-synchronous mode switching, including an animated test pattern.
//  - Pipelines valid and inside-image flags to match the RAM read latency, so pix_data aligns exactly.
// PARAMETERS
//  IMG_W        640     image width in stored pixels
//  IMG_H        480     image height in stored pixels
//  ADDR_W       19      framebuffer address width (IMG_W*IMG_H <= 2**ADDR_W)
//  DATA_W       12      pixel width, RGB444 {R[11:8],G[7:4],B[3:0]}
//  SCALE_SHIFT  0       replication factor 2**SCALE_SHIFT in x and y (0..3)
//  RAM_LAT      1       framebuffer read latency in cycles (1..3)
//  BG_COLOR     12'h000 colour driven outside the image area
// PORTS
//  pix_clk        in   1       pixel clock; all logic on rising edge
//  rst_n          in   1       asynchronous active-low reset
//  pix_x          in   12      current scan column
//  pix_y          in   12      current scan row
//  pix_valid      in   1       scan position inside active video
//  mode_req       in   2       requested mode: 0 framebuffer, 1 gradient, 2 solid BG, 3 colour bars
//  x_off          in   12      image left edge in screen pixels
//  y_off          in   12      image top edge in screen pixels
//  ram_en         out  1       framebuffer read enable
//  ram_addr       out  ADDR_W  framebuffer read address
//  ram_dout       in   DATA_W  framebuffer read data, RAM_LAT cycles after ram_addr
//  pix_data       out  DATA_W  output pixel colour
//  pix_data_vld   out  1       pix_data corresponds to an active-video pixel
//  frame_start    out  1       one-cycle pulse aligned with the first pixel of a frame on pix_data
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - ram_en=0, ram_addr=0, pix_data=0, pix_data_vld=0, frame_start=0.
//  - Active mode=0; frame counter=0; all pipeline flags=0.
//  Stage 0 (registered):
//  - rx = pix_x - x_off and ry = pix_y - y_off, as 13-bit signed values.
//  - inside = pix_valid & rx>=0 & ry>=0 & rx<(IMG_W<<SCALE_SHIFT) & ry<(IMG_H<<SCALE_SHIFT).
//  - ram_addr = (ry>>>SCALE_SHIFT)*IMG_W + (rx>>>SCALE_SHIFT), truncated to ADDR_W.
//  - ram_en = inside & (mode==0). When ram_en=0, ram_addr holds its previous value.
//  Delay pipeline:
//  - pix_valid, inside, sof and pattern data are delayed by RAM_LAT stages.
//  - sof = pix_valid & pix_x==0 & pix_y==0.
//  Output stage (registered), selected by the delayed flags:
//  - delayed pix_valid=0: pix_data=0.
//  - delayed inside=0: pix_data=BG_COLOR.
//  - otherwise, by mode:
//      mode 0: ram_dout
//      mode 1: {rx[7:4]-fc[3:0], ry[7:4]-fc[3:0], rx[7:4]+ry[7:4]} (mod 16 per field)
//      mode 2: BG_COLOR
//      mode 3: 8 vertical bars of width IMG_W/8. Bar k colour: R=k[2]?F:0, G=k[1]?F:0, B=k[0]?F:0.
//  - pix_data_vld = delayed pix_valid. frame_start = delayed sof.
//  Latency: pix_x/pix_y/pix_valid sampled at cycle N appear on pix_data, pix_data_vld and frame_start at cycle N+RAM_LAT+2.
//  Mode handshake:
//  - mode_req is sampled only on a cycle with sof=1; it becomes the active mode from that pixel onward.
//  - Changes to mode_req mid-frame never alter the current frame.
//  Frame counter fc (8-bit):
//  - Increments on each sof and wraps 255->0.
//  - fc is used by mode 1 to scroll the pattern.
//  Boundaries:
//  - Negative rx/ry and the far edges are outside the image.
//  - The last stored pixel, address IMG_W*IMG_H-1, is fetched at rx=(IMG_W<<S)-1, ry=(IMG_H<<S)-1.
//  - x_off/y_off are used as-is each cycle; software changes them only during blanking.
//  - Reset mid-frame clears the pipeline immediately. Output resumes cleanly at the next sof.
// TESTING
//  1. Release reset; mode 0, offsets 0, S=0. Scan (0,0), (1,0), (0,1), (639,479)
//     -> ram_addr = 0, 1, 640, 307199. pix_data = RAM content RAM_LAT+2 cycles after each input.
//  2. x_off=100, y_off=50. Scan (99,50) and (100,49) -> BG_COLOR, ram_en=0.
//     Scan (100,50) -> ram_addr=0.
//  3. SCALE_SHIFT=1, offsets 0. Scan (0,0), (1,0), (2,0), (0,2)
//     -> ram_addr = 0, 0, 1, IMG_W.
//     Scan (1280,0) -> outside, pix_data=BG_COLOR.
//  4. Set mode_req=3 mid-frame -> bars appear only after the next sof.
//     In bars mode: x=0 -> 12'h000, x=80 -> 12'h00F, x=560 -> 12'hFFF.
//  5. Mode 1, two consecutive frames at (16,0) -> R field differs by exactly 1 between frames.
//     After 256 frames the pattern repeats.
//  6. Assert rst_n low mid-line -> all outputs 0 the same cycle.
//     After release, frame_start first pulses RAM_LAT+2 cycles after the next (0,0).

Source files
------------

// File: rtl/vga_fb_reader.sv
// Framebuffer pixel fetcher: maps the VGA scan position to a framebuffer
// address, handles offset/replication/background, generates test patterns
// and keeps all flags aligned with the RAM read latency.
module vga_fb_reader #(
    parameter int                IMG_W       = 640,
    parameter int                IMG_H       = 480,
    parameter int                ADDR_W      = 19,
    parameter int                DATA_W      = 12,
    parameter int                SCALE_SHIFT = 0,
    parameter int                RAM_LAT     = 1,
    parameter logic [DATA_W-1:0] BG_COLOR    = '0
) (
    input  logic              pix_clk,
    input  logic              rst_n,
    input  logic [11:0]       pix_x,
    input  logic [11:0]       pix_y,
    input  logic              pix_valid,
    input  logic [1:0]        mode_req,
    input  logic [11:0]       x_off,
    input  logic [11:0]       y_off,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_data_vld,
    output logic              frame_start
);

    localparam int IMG_W_S = IMG_W << SCALE_SHIFT;
    localparam int IMG_H_S = IMG_H << SCALE_SHIFT;
    localparam int BAR_W   = IMG_W / 8;

    logic signed [12:0] rx, ry;
    logic [12:0]        ix, iy;
    logic [25:0]        addr_wide;
    logic               inside_c, sof_c;
    logic [1:0]         mode_eff;
    logic [7:0]         fc_eff;
    logic [3:0]         grad_r, grad_g, grad_b;
    logic [2:0]         bar_k;
    logic [DATA_W-1:0]  pat_c;

    logic [1:0]        mode_q, mode_d;
    logic [7:0]        fc_q, fc_d;
    logic              ram_en_q, ram_en_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;

    // Index 0 is the stage-0 register; index RAM_LAT lines up with ram_dout.
    logic [RAM_LAT:0]  vld_pipe_q, vld_pipe_d;
    logic [RAM_LAT:0]  in_pipe_q, in_pipe_d;
    logic [RAM_LAT:0]  sof_pipe_q, sof_pipe_d;
    logic [RAM_LAT:0]  fb_pipe_q, fb_pipe_d;
    logic [DATA_W-1:0] pat_pipe_q [RAM_LAT+1];
    logic [DATA_W-1:0] pat_pipe_d [RAM_LAT+1];

    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              pix_data_vld_q, pix_data_vld_d;
    logic              frame_start_q, frame_start_d;

    // Stage 0: position mapping, mode/frame bookkeeping and pattern generation
    always_comb begin
        rx = $signed({1'b0, pix_x}) - $signed({1'b0, x_off});
        ry = $signed({1'b0, pix_y}) - $signed({1'b0, y_off});
        ix = rx >>> SCALE_SHIFT;
        iy = ry >>> SCALE_SHIFT;
        inside_c = pix_valid && !rx[12] && !ry[12]
                   && ({2'b00, rx[11:0]} < 14'(IMG_W_S))
                   && ({2'b00, ry[11:0]} < 14'(IMG_H_S));
        sof_c = pix_valid && (pix_x == 12'd0) && (pix_y == 12'd0);
        // The sof pixel already belongs to the new frame, so it sees the new mode and count.
        mode_eff = sof_c ? mode_req : mode_q;
        fc_eff   = sof_c ? fc_q + 8'd1 : fc_q;
        mode_d   = mode_eff;
        fc_d     = fc_eff;

        addr_wide  = 26'(iy) * 26'(IMG_W) + 26'(ix);
        ram_en_d   = inside_c && (mode_eff == 2'd0);
        ram_addr_d = ram_en_d ? addr_wide[ADDR_W-1:0] : ram_addr_q;

        grad_r = rx[7:4] - fc_eff[3:0];
        grad_g = ry[7:4] - fc_eff[3:0];
        grad_b = rx[7:4] + ry[7:4];
        bar_k  = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (ix >= 13'(i * BAR_W)) bar_k = 3'(i);
        end
        case (mode_eff)
            2'd1:    pat_c = DATA_W'({grad_r, grad_g, grad_b});
            2'd3:    pat_c = DATA_W'({{4{bar_k[2]}}, {4{bar_k[1]}}, {4{bar_k[0]}}});
            default: pat_c = BG_COLOR;
        endcase
    end

    // Flag and pattern delay line matching the RAM read latency
    always_comb begin
        vld_pipe_d    = {vld_pipe_q[RAM_LAT-1:0], pix_valid};
        in_pipe_d     = {in_pipe_q[RAM_LAT-1:0], inside_c};
        sof_pipe_d    = {sof_pipe_q[RAM_LAT-1:0], sof_c};
        fb_pipe_d     = {fb_pipe_q[RAM_LAT-1:0], (mode_eff == 2'd0)};
        pat_pipe_d[0] = pat_c;
        for (int i = 1; i <= RAM_LAT; i++) begin
            pat_pipe_d[i] = pat_pipe_q[i-1];
        end
    end

    // Output select from the delayed flags
    always_comb begin
        if (!vld_pipe_q[RAM_LAT])
            pix_data_d = '0;
        else if (!in_pipe_q[RAM_LAT])
            pix_data_d = BG_COLOR;
        else if (fb_pipe_q[RAM_LAT])
            pix_data_d = ram_dout;
        else
            pix_data_d = pat_pipe_q[RAM_LAT];
        pix_data_vld_d = vld_pipe_q[RAM_LAT];
        frame_start_d  = sof_pipe_q[RAM_LAT];
    end

    // All state registers; reset clears the whole pipeline at once
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q         <= 2'd0;
            fc_q           <= 8'd0;
            ram_en_q       <= 1'b0;
            ram_addr_q     <= '0;
            vld_pipe_q     <= '0;
            in_pipe_q      <= '0;
            sof_pipe_q     <= '0;
            fb_pipe_q      <= '0;
            for (int i = 0; i <= RAM_LAT; i++) pat_pipe_q[i] <= '0;
            pix_data_q     <= '0;
            pix_data_vld_q <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            fc_q           <= fc_d;
            ram_en_q       <= ram_en_d;
            ram_addr_q     <= ram_addr_d;
            vld_pipe_q     <= vld_pipe_d;
            in_pipe_q      <= in_pipe_d;
            sof_pipe_q     <= sof_pipe_d;
            fb_pipe_q      <= fb_pipe_d;
            for (int i = 0; i <= RAM_LAT; i++) pat_pipe_q[i] <= pat_pipe_d[i];
            pix_data_q     <= pix_data_d;
            pix_data_vld_q <= pix_data_vld_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign ram_en       = ram_en_q;
    assign ram_addr     = ram_addr_q;
    assign pix_data     = pix_data_q;
    assign pix_data_vld = pix_data_vld_q;
    assign frame_start  = frame_start_q;

endmodule
